// File: rtl/spi_master_gen_if.sv
// Front-end bus of spi_master_gen: transfer request, per-transfer config and result.
`timescale 1ns/1ps
interface spi_master_gen_if #(
    parameter int DWIDTH = 8,
    parameter int SS_W   = 1
);
    logic              start;
    logic [SS_W-1:0]   ss_sel;
    logic              cpol;
    logic              cpha;
    logic [DWIDTH-1:0] tx_data;
    logic [DWIDTH-1:0] rx_data;
    logic              busy;
    logic              done;

    modport master (
        output start, ss_sel, cpol, cpha, tx_data,
        input  rx_data, busy, done
    );

    modport slave (
        input  start, ss_sel, cpol, cpha, tx_data,
        output rx_data, busy, done
    );
endinterface

// File: rtl/spi_master_gen.sv
// Parametrised SPI master, all four CPOL/CPHA modes, MSB first, registered outputs.
// Optional build macro SPI_LOOPBACK_EN adds a latched loopback input (rx sampled from mosi).
`timescale 1ns/1ps
module spi_master_gen #(
    parameter int DWIDTH  = 8,
    parameter int NUM_SS  = 2,
    parameter int CLK_DIV = 2,
    parameter int SS_W    = 1
) (
    input  logic              clk,
    input  logic              reset,
    spi_master_gen_if.slave   bus,
`ifdef SPI_LOOPBACK_EN
    input  logic              loopback,
`endif
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_SS-1:0] ss_n
);

    localparam int EDGES  = 2 * DWIDTH;
    localparam int EDGE_W = $clog2(EDGES + 1);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(EDGES - 1);
    localparam logic [SS_W:0]     NUM_SS_L  = (SS_W + 1)'(NUM_SS);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SETUP    = 2'd1,
        S_TRANSFER = 2'd2,
        S_HOLD     = 2'd3
    } state_t;

    state_t              state_r;
    logic [DIV_W-1:0]    div_cnt_r;
    logic [EDGE_W-1:0]   edge_cnt_r;
    logic [DWIDTH-1:0]   tx_sh_r;
    logic [DWIDTH-1:0]   rx_sh_r;
    logic [DWIDTH-1:0]   rx_data_r;
    logic                cpol_r;
    logic                cpha_r;
    logic                sclk_r;
    logic                mosi_r;
    logic [NUM_SS-1:0]   ss_n_r;
    logic                busy_r;
    logic                done_r;
    logic                lb_r;

    logic                accept_s;
    logic                div_last_s;
    logic                last_edge_s;
    logic                sample_edge_s;
    logic                sample_bit_s;
    logic                lb_in_s;

    function automatic logic [NUM_SS-1:0] ss_decode(input logic [SS_W-1:0] sel);
        logic [NUM_SS-1:0] v;
        v = '1;
        for (int i = 0; i < NUM_SS; i++) begin
            if (sel == SS_W'(i)) v[i] = 1'b0;
            else                 v[i] = 1'b1;
        end
        return v;
    endfunction

`ifdef SPI_LOOPBACK_EN
    assign lb_in_s = loopback;
`else
    assign lb_in_s = 1'b0;
`endif

    // The done cycle is already IDLE but must not accept a new request.
    assign accept_s      = (state_r == S_IDLE) && !done_r && bus.start &&
                           ({1'b0, bus.ss_sel} < NUM_SS_L);
    assign div_last_s    = (div_cnt_r == DIV_LAST);
    assign last_edge_s   = (edge_cnt_r == EDGE_LAST);
    // Edge k = edge_cnt_r+1 is leading when edge_cnt_r is even; cpha flips which edge samples.
    assign sample_edge_s = (~edge_cnt_r[0]) ^ cpha_r;
    assign sample_bit_s  = lb_r ? mosi_r : miso;

    // Transfer sequencer with registered SPI pins and bus outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= S_IDLE;
            div_cnt_r  <= '0;
            edge_cnt_r <= '0;
            tx_sh_r    <= '0;
            rx_sh_r    <= '0;
            rx_data_r  <= '0;
            cpol_r     <= 1'b0;
            cpha_r     <= 1'b0;
            lb_r       <= 1'b0;
            sclk_r     <= 1'b0;
            mosi_r     <= 1'b0;
            ss_n_r     <= '1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        state_r    <= S_SETUP;
                        busy_r     <= 1'b1;
                        ss_n_r     <= ss_decode(bus.ss_sel);
                        cpol_r     <= bus.cpol;
                        cpha_r     <= bus.cpha;
                        lb_r       <= lb_in_s;
                        sclk_r     <= bus.cpol;
                        div_cnt_r  <= '0;
                        edge_cnt_r <= '0;
                        // cpha=0 drives the MSB now; the shifter then holds the remaining bits.
                        if (bus.cpha) begin
                            mosi_r  <= 1'b0;
                            tx_sh_r <= bus.tx_data;
                        end else begin
                            mosi_r  <= bus.tx_data[DWIDTH-1];
                            tx_sh_r <= {bus.tx_data[DWIDTH-2:0], 1'b0};
                        end
                    end else begin
                        sclk_r <= bus.cpol;
                        mosi_r <= 1'b0;
                        ss_n_r <= '1;
                    end
                end
                S_SETUP, S_TRANSFER: begin
                    if (div_last_s) begin
                        div_cnt_r  <= '0;
                        edge_cnt_r <= edge_cnt_r + EDGE_W'(1);
                        sclk_r     <= ~sclk_r;
                        state_r    <= last_edge_s ? S_HOLD : S_TRANSFER;
                        if (sample_edge_s) begin
                            rx_sh_r <= {rx_sh_r[DWIDTH-2:0], sample_bit_s};
                        end else if (!last_edge_s) begin
                            mosi_r  <= tx_sh_r[DWIDTH-1];
                            tx_sh_r <= {tx_sh_r[DWIDTH-2:0], 1'b0};
                        end else begin
                            mosi_r  <= mosi_r;
                        end
                    end else begin
                        div_cnt_r <= div_cnt_r + DIV_W'(1);
                    end
                end
                S_HOLD: begin
                    if (div_last_s) begin
                        state_r   <= S_IDLE;
                        div_cnt_r <= '0;
                        done_r    <= 1'b1;
                        busy_r    <= 1'b0;
                        ss_n_r    <= '1;
                        mosi_r    <= 1'b0;
                        rx_data_r <= rx_sh_r;
                    end else begin
                        div_cnt_r <= div_cnt_r + DIV_W'(1);
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    ss_n_r  <= '1;
                    mosi_r  <= 1'b0;
                end
            endcase
        end
    end

    assign sclk        = sclk_r;
    assign mosi        = mosi_r;
    assign ss_n        = ss_n_r;
    assign bus.rx_data = rx_data_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;

endmodule

// File: tb/tb_spi_master_gen.sv
// Self-checking bench: per-cycle comparison against a timeline model of the SPI transfer.
`timescale 1ns/1ps
module tb_spi_master_gen;
    localparam int DW    = 8;
    localparam int NSS   = 2;
    localparam int CD    = 2;
    localparam int SW    = 2;
    localparam int NEDGE = 2 * DW;
    localparam int DJ    = (2 * DW + 1) * CD + 1;   // accept cycle to done cycle

    logic           clk = 1'b0;
    logic           reset;
    logic           sclk, mosi, miso;
    logic [NSS-1:0] ss_n;
    logic           loopback;

    spi_master_gen_if #(.DWIDTH(DW), .SS_W(SW)) bus ();

    spi_master_gen #(.DWIDTH(DW), .NUM_SS(NSS), .CLK_DIV(CD), .SS_W(SW)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
`ifdef SPI_LOOPBACK_EN
        .loopback (loopback),
`endif
        .sclk     (sclk),
        .mosi     (mosi),
        .miso     (miso),
        .ss_n     (ss_n)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model state
    int              cyc = 0;
    bit              active = 1'b0;
    int              a_cyc, done_cyc = -1, ready_cyc = 0;
    logic [DW-1:0]   m_tx, m_slave, rx_exp = '0;
    logic            m_cpol, m_cpha, m_lb;
    logic [SW-1:0]   m_sel;
    logic            idle_sclk_exp = 1'b0;
    bit              rst_edge = 1'b1;

    // stimulus
    logic            drv_start = 1'b0, drv_cpol = 1'b0, drv_cpha = 1'b0, drv_reset = 1'b1, drv_lb = 1'b0;
    logic [SW-1:0]   drv_sel = '0;
    logic [DW-1:0]   drv_tx = '0, next_slave = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int edges_at(input int j);
        int e;
        e = (j - 1) / CD;
        return (e > NEDGE) ? NEDGE : e;
    endfunction

    // Index of the bit on the line after e edges; -1 before the first bit is driven.
    function automatic int bit_idx(input int e, input logic cpha);
        int i;
        if (!cpha) begin
            i = e / 2;
            return (i > DW - 1) ? DW - 1 : i;
        end
        return (e == 0) ? -1 : (e - 1) / 2;
    endfunction

    task automatic model_reset();
        active    = 1'b0;
        rx_exp    = '0;
        done_cyc  = -1;
        ready_cyc = 0;
    endtask

    task automatic step();
        int e, idx;
        @(posedge clk);
        cyc++;
        rst_edge = reset;
        if (reset) begin
            model_reset();
        end else begin
            if (active && cyc == a_cyc + DJ) begin
                active = 1'b0;
                rx_exp = m_lb ? m_tx : m_slave;
            end else if (!active && cyc >= ready_cyc && bus.start && bus.ss_sel < NSS) begin
                a_cyc     = cyc - 1;
                m_tx      = bus.tx_data;
                m_cpol    = bus.cpol;
                m_cpha    = bus.cpha;
                m_sel     = bus.ss_sel;
`ifdef SPI_LOOPBACK_EN
                m_lb      = loopback;
`else
                m_lb      = 1'b0;
`endif
                m_slave   = next_slave;
                active    = 1'b1;
                done_cyc  = a_cyc + DJ;
                ready_cyc = done_cyc + 2;
            end
            idle_sclk_exp = bus.cpol;
        end
        #1;
        reset = drv_reset;
        if (drv_reset) model_reset();
        bus.start   = drv_start;
        bus.ss_sel  = drv_sel;
        bus.cpol    = drv_cpol;
        bus.cpha    = drv_cpha;
        bus.tx_data = drv_tx;
        loopback    = drv_lb;
        miso        = 1'($urandom);
        if (active) begin
            e   = edges_at(cyc - a_cyc);
            idx = bit_idx(e, m_cpha);
            if (idx >= 0) miso = m_slave[DW-1-idx];
        end
        @(negedge clk);
    endtask

    // Per-cycle comparison of every output against the model timeline.
    always @(negedge clk) begin
        logic [NSS-1:0] e_ss;
        logic e_sclk, e_mosi, e_busy, e_done;
        int j, e, idx;
        e_ss = '1; e_sclk = 1'b0; e_mosi = 1'b0; e_busy = 1'b0; e_done = 1'b0;
        if (reset || rst_edge) begin
            e_sclk = 1'b0;
        end else if (active) begin
            j   = cyc - a_cyc;
            e   = edges_at(j);
            idx = bit_idx(e, m_cpha);
            e_ss[m_sel] = 1'b0;
            e_sclk = m_cpol ^ e[0];
            e_mosi = (idx < 0) ? 1'b0 : m_tx[DW-1-idx];
            e_busy = 1'b1;
        end else if (cyc == done_cyc) begin
            e_sclk = m_cpol;
            e_done = 1'b1;
        end else begin
            e_sclk = idle_sclk_exp;
        end
        chk("sclk", 32'(sclk), 32'(e_sclk));
        chk("mosi", 32'(mosi), 32'(e_mosi));
        chk("ss_n", 32'(ss_n), 32'(e_ss));
        chk("busy", 32'(bus.busy), 32'(e_busy));
        chk("done", 32'(bus.done), 32'(e_done));
        chk("rx_data", 32'(bus.rx_data), 32'(rx_exp));
    end

    task automatic run_xfer(input logic [SW-1:0] sel, input logic cpol, input logic cpha,
                            input logic [DW-1:0] tx, input logic [DW-1:0] slave,
                            output int doff, output logic [DW-1:0] mword,
                            output logic [NSS-1:0] ss_seen);
        drv_start = 1'b1; drv_sel = sel; drv_cpol = cpol; drv_cpha = cpha; drv_tx = tx;
        next_slave = slave;
        step();
        drv_start = 1'b0;
        doff = -1; mword = '0; ss_seen = '0;
        for (int n = 1; n <= DJ + 4; n++) begin
            step();
            if (n == 1) ss_seen = ss_n;
            for (int i = 0; i < DW; i++) begin
                if (n == (cpha ? (2 * i + 1) * CD + 1 : 2 * i * CD + 1)) mword[DW-1-i] = mosi;
            end
            if (bus.done && doff < 0) doff = n;
        end
        if (doff < 0) $display("FAIL xfer_timeout: got no done expected done within %0d", DJ + 4);
    endtask

    initial begin
        int doff, ndone, nbusy, first_d, second_d;
        logic [DW-1:0] mword;
        logic [NSS-1:0] ss_seen;
        logic cp;

        reset = 1'b1; miso = 1'b0; loopback = 1'b0;
        bus.start = 1'b0; bus.ss_sel = '0; bus.cpol = 1'b0; bus.cpha = 1'b0; bus.tx_data = '0;
        repeat (3) step();
        chk("reset_ss_n", 32'(ss_n), 32'h3);
        chk("reset_sclk", 32'(sclk), 32'h0);
        chk("reset_busy", 32'(bus.busy), 32'h0);
        chk("reset_rx", 32'(bus.rx_data), 32'h0);
        drv_reset = 1'b0;
        repeat (3) step();

        // reset right after edge 5 of a transfer
        drv_start = 1'b1; drv_sel = 1'b0; drv_cpol = 1'b0; drv_cpha = 1'b0; drv_tx = 8'hC3;
        next_slave = 8'h96;
        step();
        drv_start = 1'b0;
        repeat (10) step();
        chk("pre_abort_busy", 32'(bus.busy), 32'h1);
        drv_reset = 1'b1;
        step();
        chk("abort_ss_n", 32'(ss_n), 32'h3);
        chk("abort_sclk", 32'(sclk), 32'h0);
        chk("abort_busy", 32'(bus.busy), 32'h0);
        drv_reset = 1'b0;
        ndone = 0;
        for (int n = 0; n < DJ + 5; n++) begin
            step();
            if (bus.done) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'h0);
        chk("abort_rx", 32'(bus.rx_data), 32'h0);

        // mode 0 directed transfer
        run_xfer(2'd1, 1'b0, 1'b0, 8'hA5, 8'h3C, doff, mword, ss_seen);
        chk("m0_done_off", 32'(doff), 32'd35);
        chk("m0_mosi", 32'(mword), 32'hA5);
        chk("m0_ss_n", 32'(ss_seen), 32'h1);
        chk("m0_rx", 32'(bus.rx_data), 32'h3C);

        // modes 1..3
        for (int m = 1; m < 4; m++) begin
            cp = (m >= 2);
            run_xfer(2'd0, cp, 1'(m % 2), 8'h81, 8'h7E, doff, mword, ss_seen);
            chk("mode_done_off", 32'(doff), 32'd35);
            chk("mode_mosi", 32'(mword), 32'h81);
            chk("mode_ss_n", 32'(ss_seen), 32'h2);
            chk("mode_rx", 32'(bus.rx_data), 32'h7E);
            chk("mode_idle_sclk", 32'(sclk), 32'(cp));
        end

`ifdef SPI_LOOPBACK_EN
        drv_lb = 1'b1;
        run_xfer(2'd1, 1'b0, 1'b0, 8'h5A, 8'h00, doff, mword, ss_seen);
        chk("loopback_rx", 32'(bus.rx_data), 32'h5A);
        drv_lb = 1'b0;
`endif

        // start held high: back-to-back transfers, inputs churn during transfers
        repeat (2) step();
        drv_start = 1'b1; drv_sel = 2'd1;
        ndone = 0; first_d = -1; second_d = -1;
        for (int n = 0; n < 120; n++) begin
            drv_tx = DW'($urandom); drv_cpol = 1'($urandom); drv_cpha = 1'($urandom);
            next_slave = DW'($urandom);
            step();
            if (bus.done) begin
                ndone++;
                if (first_d < 0) first_d = n;
                else if (second_d < 0) second_d = n;
            end
        end
        drv_start = 1'b0;
        chk("b2b_count", 32'(ndone), 32'd3);
        chk("b2b_gap", 32'(second_d - first_d), 32'd36);
        repeat (DJ + 2) step();

        // out-of-range slave select is ignored
        drv_start = 1'b1; nbusy = 0;
        for (int n = 0; n < 20; n++) begin
            drv_sel = 2'd2 + 2'(n % 2);
            step();
            if (bus.busy) nbusy++;
        end
        drv_start = 1'b0;
        chk("bad_sel_busy", 32'(nbusy), 32'h0);

        // randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            drv_start  = ($urandom_range(5) == 0);
            drv_sel    = SW'($urandom);
            drv_cpol   = 1'($urandom);
            drv_cpha   = 1'($urandom);
            drv_tx     = DW'($urandom);
            drv_lb     = 1'($urandom);
            drv_reset  = ($urandom_range(699) == 0);
            next_slave = DW'($urandom);
            step();
        end
        drv_reset = 1'b0; drv_start = 1'b0;
        repeat (DJ + 2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
